// File: rtl/key_check_consumer_pkg.sv
// Shared definitions for the key-check consumer.
//   state_t   : FSM state encoding (also exported on the debug port)
//   KEY_W     : candidate key width
//   BLK_W     : cipher/plaintext block width
//   key_round : one decrypt round, work = rotr(work, rot) ^ {key, ~key}
package key_pkg;

  localparam int KEY_W = 32;
  localparam int BLK_W = 64;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_KEY = 3'd1,
    ROUND    = 3'd2,
    CMP      = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Right-rotate by doubling the word and shifting, then mix in the key
  // and its complement.
  function automatic logic [BLK_W-1:0] key_round(
    input logic [BLK_W-1:0] work,
    input logic [KEY_W-1:0] key,
    input int unsigned      rot
  );
    logic [2*BLK_W-1:0] dbl;
    dbl = {work, work} >> rot;
    return dbl[BLK_W-1:0] ^ {key, ~key};
  endfunction

endpackage

// File: rtl/key_check_consumer_round_unit.sv
// Combinational single decrypt round.
//   work   : current 64-bit working block
//   key    : 32-bit candidate key
//   result : block after one round
module key_round_unit
  import key_pkg::*;
#(
  parameter int unsigned ROT = 8
) (
  input  logic [BLK_W-1:0] work,
  input  logic [KEY_W-1:0] key,
  output logic [BLK_W-1:0] result
);

  assign result = key_round(work, key, ROT);

endmodule

// File: rtl/key_check_consumer.sv
// Consumer end of the accelerator key queue. Pops candidate keys, runs a
// ROUNDS-round iterative decrypt of the latched ciphertext with each key
// and compares against the latched target; reports hit or abort.
//   clk, rst       : clock, synchronous active-high reset
//   start, stop    : begin search (latches cipherIn/target) / abort search
//   cipherIn       : ciphertext block
//   target         : expected plaintext
//   keyIn, Qempty  : head-of-queue key (first-word-fall-through), empty flag
//   popQ           : dequeue strobe
//   dataToReg      : result word {tried, key} on hit, {tried, 0} on abort
//   incrPC         : one-cycle completion pulse
//   found          : match flag, held until the next start
//   busy           : high in every state except IDLE
//   state_dbg      : current FSM state
//
// Queue handshake: the queue offers keyIn whenever Qempty=0; popQ=1 in a
// cycle means keyIn is consumed at the end of that cycle. popQ is never
// raised while Qempty=1 or while stop=1.
module key_check_consumer
  import key_pkg::*;
#(
  parameter int unsigned ROUNDS = 4,
  parameter int unsigned ROT    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [BLK_W-1:0] cipherIn,
  input  logic [BLK_W-1:0] target,
  input  logic [KEY_W-1:0] keyIn,
  input  logic             Qempty,
  output logic             popQ,
  output logic [BLK_W-1:0] dataToReg,
  output logic             incrPC,
  output logic             found,
  output logic             busy,
  output state_t           state_dbg
);

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  state_t           state;
  state_t           state_next;
  logic [BLK_W-1:0] cipher;
  logic [BLK_W-1:0] tgt;
  logic [BLK_W-1:0] work;
  logic [BLK_W-1:0] round_out;
  logic [KEY_W-1:0] key;
  logic [3:0]       rnd;
  logic [31:0]      tried;
  logic [31:0]      tried_inc;
  logic             found_r;
  logic [BLK_W-1:0] data_r;
  logic             searching;
  logic             hit;

  key_round_unit #(.ROT(ROT)) u_round (
    .work   (work),
    .key    (key),
    .result (round_out)
  );

  assign tried_inc = (tried == 32'hFFFF_FFFF) ? tried : tried + 32'd1;
  assign hit       = (work == tgt);
  // States in which stop aborts the search.
  assign searching = (state == WAIT_KEY) || (state == ROUND) || (state == CMP);

  always_comb begin
    state_next = state;
    popQ       = 1'b0;
    case (state)
      IDLE:     if (start && !stop) state_next = WAIT_KEY;
      WAIT_KEY: begin
        if (stop) begin
          state_next = DONE;
        end else if (!Qempty) begin
          popQ       = 1'b1;
          state_next = ROUND;
        end
      end
      ROUND: begin
        if (stop)                 state_next = DONE;
        else if (rnd == LAST_RND) state_next = CMP;
      end
      CMP: begin
        if (stop || hit) state_next = DONE;
        else             state_next = WAIT_KEY;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cipher  <= '0;
      tgt     <= '0;
      work    <= '0;
      key     <= '0;
      rnd     <= '0;
      tried   <= '0;
      found_r <= 1'b0;
      data_r  <= '0;
    end else begin
      state <= state_next;
      if (stop && searching) begin
        // Abort wins over a pop or a same-cycle match; the key under test
        // is not counted.
        found_r <= 1'b0;
        data_r  <= {tried, 32'h0};
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              cipher  <= cipherIn;
              tgt     <= target;
              tried   <= '0;
              found_r <= 1'b0;
            end
          end
          WAIT_KEY: begin
            if (!Qempty) begin
              key  <= keyIn;
              work <= cipher;
              rnd  <= '0;
            end
          end
          ROUND: begin
            work <= round_out;
            rnd  <= rnd + 4'd1;
          end
          CMP: begin
            tried <= tried_inc;
            if (hit) begin
              found_r <= 1'b1;
              data_r  <= {tried_inc, key};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign incrPC    = (state == DONE);
  assign busy      = (state != IDLE);
  assign found     = found_r;
  assign dataToReg = data_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_key_check_consumer.sv
// Self-checking bench for key_check_consumer: directed scenarios plus
// randomized searches, checked against a cycle-level outcome model.
module tb_key_check_consumer;
  import key_pkg::*;

  localparam int R  = 4;
  localparam int RT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [63:0] cipherIn;
  logic [63:0] target;
  logic [31:0] keyIn;
  logic        Qempty;
  logic        popQ;
  logic [63:0] dataToReg;
  logic        incrPC;
  logic        found;
  logic        busy;
  state_t      state_dbg;

  key_check_consumer #(.ROUNDS(R), .ROT(RT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cipherIn  (cipherIn),
    .target    (target),
    .keyIn     (keyIn),
    .Qempty    (Qempty),
    .popQ      (popQ),
    .dataToReg (dataToReg),
    .incrPC    (incrPC),
    .found     (found),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] key_q[$];
  int          cyc;
  int          starve_end;

  int          s_cyc;
  logic        s_pop, s_incr, s_found, s_busy, s_qe, s_stop;
  logic [63:0] s_data;
  state_t      s_state;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: decrypt written straight from the round definition.
  function automatic logic [63:0] decrypt(input logic [63:0] c, input logic [31:0] k);
    logic [63:0] w;
    w = c;
    for (int i = 0; i < R; i++) begin
      w = ((w >> RT) | (w << (64 - RT))) ^ {k, ~k};
    end
    return w;
  endfunction

  // Outcome model: walks the key list with per-key cost of R+2 cycles,
  // delaying pops until the queue is offered and honouring stop.
  task automatic predict(input logic [63:0] c, input logic [63:0] t, input logic [31:0] keys[$],
                         input int starve, input int stop_c, output int done_c,
                         output logic f, output logic [63:0] d, output int pc[$]);
    int cur;
    int p;
    int tried;
    cur = 1; tried = 0; done_c = -1; f = 1'b0; d = 64'h0; pc.delete();
    for (int i = 0; i < keys.size() && done_c < 0; i++) begin
      p = (starve > cur) ? starve : cur;
      if (stop_c >= cur && stop_c <= p + R + 1) begin
        if (stop_c > p) pc.push_back(p);
        done_c = stop_c + 1; f = 1'b0; d = {32'(tried), 32'h0};
      end else begin
        pc.push_back(p);
        tried++;
        if (decrypt(c, keys[i]) == t) begin
          done_c = p + R + 2; f = 1'b1; d = {32'(tried), keys[i]};
        end else begin
          cur = p + R + 2;
        end
      end
    end
    if (done_c < 0 && stop_c >= cur) begin
      done_c = stop_c + 1; f = 1'b0; d = {32'(tried), 32'h0};
    end
  endtask

  // Driver tasks
  task automatic drive_q();
    Qempty = (key_q.size() == 0) || (cyc < starve_end);
    keyIn  = (key_q.size() != 0) ? key_q[0] : 32'($urandom);
  endtask

  task automatic cycle();
    @(negedge clk);
    s_cyc = cyc; s_pop = popQ; s_incr = incrPC; s_found = found; s_busy = busy;
    s_data = dataToReg; s_state = state_dbg; s_qe = Qempty; s_stop = stop;
    @(posedge clk);
    #1;
    if (s_pop && key_q.size() > 0) void'(key_q.pop_front());
    cyc++;
    drive_q();
  endtask

  task automatic run(input string tag, input logic [63:0] c, input logic [63:0] t,
                     input logic [31:0] keys[$], input int starve, input int stop_c,
                     input int restart_c);
    int          exp_done, obs_done;
    logic        exp_f, obs_f, busy_ok;
    logic [63:0] exp_d, obs_d;
    int          exp_pc[$];
    int          obs_pc[$];
    predict(c, t, keys, starve, stop_c, exp_done, exp_f, exp_d, exp_pc);
    key_q = keys; cyc = 0; starve_end = starve; drive_q();
    cipherIn = c; target = t; start = 1'b1; stop = 1'b0;
    cycle();
    start = 1'b0;
    obs_done = -1; busy_ok = 1'b1; obs_f = 1'b0; obs_d = 64'h0;
    while (obs_done < 0 && cyc < 400) begin
      start    = (cyc == restart_c);
      stop     = (cyc == stop_c);
      cipherIn = {$urandom, $urandom};
      target   = {$urandom, $urandom};
      cycle();
      if (!s_busy) busy_ok = 1'b0;
      if (s_cyc == 1) chk({tag, " found_cleared"}, 64'(s_found), 64'd0);
      if (s_pop) begin
        obs_pc.push_back(s_cyc);
        chk({tag, " pop_while_empty"}, 64'(s_qe), 64'd0);
        chk({tag, " pop_with_stop"}, 64'(s_stop), 64'd0);
      end
      if (s_incr) begin
        obs_done = s_cyc; obs_f = s_found; obs_d = s_data;
      end
    end
    start = 1'b0; stop = 1'b0;
    chk({tag, " done_cycle"}, 64'(obs_done), 64'(exp_done));
    chk({tag, " found"}, 64'(obs_f), 64'(exp_f));
    chk({tag, " data"}, obs_d, exp_d);
    chk({tag, " busy_during_search"}, 64'(busy_ok), 64'd1);
    chk({tag, " pop_count"}, 64'(obs_pc.size()), 64'(exp_pc.size()));
    for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++)
      chk($sformatf("%s pop_cycle%0d", tag, i), 64'(obs_pc[i]), 64'(exp_pc[i]));
    cycle();
    chk({tag, " idle_busy"}, 64'(s_busy), 64'd0);
    chk({tag, " idle_incr"}, 64'(s_incr), 64'd0);
    chk({tag, " idle_state"}, 64'(s_state), 64'(IDLE));
    chk({tag, " data_held"}, s_data, exp_d);
  endtask

  logic [31:0] ks[$];
  logic [63:0] rc, rt;
  int          n, h, st, sp, rs;
  logic        quiet;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cipherIn = 64'h0; target = 64'h0;
    cyc = 0; starve_end = 0; drive_q();

    // Reset state
    cycle(); cycle();
    chk("reset popQ", 64'(s_pop), 64'd0);
    chk("reset incrPC", 64'(s_incr), 64'd0);
    chk("reset found", 64'(s_found), 64'd0);
    chk("reset busy", 64'(s_busy), 64'd0);
    chk("reset data", s_data, 64'h0);
    chk("reset state", 64'(s_state), 64'(IDLE));
    rst = 1'b0;
    cycle();

    // Single-key hit
    ks = '{32'h1234_5678};
    run("single_hit", 64'h0, decrypt(64'h0, 32'h1234_5678), ks, 0, -1, -1);

    // start+stop together in IDLE: no state change, found held
    start = 1'b1; stop = 1'b1; cipherIn = 64'h1; target = 64'h2;
    cycle();
    start = 1'b0; stop = 1'b0;
    cycle();
    chk("idle_start_stop busy", 64'(s_busy), 64'd0);
    chk("idle_start_stop state", 64'(s_state), 64'(IDLE));
    chk("idle_start_stop found_held", 64'(s_found), 64'd1);

    // Miss then hit
    ks = '{32'hDEAD_BEEF, 32'h1234_5678};
    run("miss_hit", 64'h0, decrypt(64'h0, 32'h1234_5678), ks, 0, -1, -1);

    // Queue starvation: empty for cycles 1..10
    ks = '{32'h1234_5678};
    run("starve", 64'h0, decrypt(64'h0, 32'h1234_5678), ks, 11, -1, -1);

    // Abort in ROUND of the second key after one miss
    ks = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1111_2222};
    run("abort", 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, ks, 0, 1 + (R + 2) + 2, -1);

    // stop in WAIT_KEY with a key offered: no pop
    ks = '{32'h1234_5678};
    run("stop_wait", 64'h0, decrypt(64'h0, 32'h1234_5678), ks, 0, 1, -1);

    // stop in WAIT_KEY while starved
    run("stop_starved", 64'h0, decrypt(64'h0, 32'h1234_5678), ks, 8, 4, -1);

    // stop in the CMP cycle of a matching key: abort wins
    run("stop_cmp", 64'h0, decrypt(64'h0, 32'h1234_5678), ks, 0, R + 2, -1);

    // start during ROUND (with cipherIn/target churning) has no effect
    ks = '{32'hA5A5_5A5A, 32'h0F0F_F0F0};
    run("restart_round", 64'h5555_AAAA_0000_FFFF, decrypt(64'h5555_AAAA_0000_FFFF, 32'h0F0F_F0F0),
        ks, 0, -1, 3);

    // Reset mid-operation
    key_q = '{32'h1234_5678}; cyc = 0; starve_end = 0; drive_q();
    cipherIn = 64'h0; target = decrypt(64'h0, 32'h1234_5678); start = 1'b1;
    cycle();
    start = 1'b0;
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("midrst popQ", 64'(s_pop), 64'd0);
    chk("midrst incrPC", 64'(s_incr), 64'd0);
    chk("midrst found", 64'(s_found), 64'd0);
    chk("midrst busy", 64'(s_busy), 64'd0);
    chk("midrst data", s_data, 64'h0);
    chk("midrst state", 64'(s_state), 64'(IDLE));
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_incr || s_busy) quiet = 1'b0;
    end
    chk("midrst no_pulse", 64'(quiet), 64'd1);
    ks = '{32'h7777_8888, 32'h1234_5678};
    run("after_rst", 64'h0, decrypt(64'h0, 32'h1234_5678), ks, 0, -1, -1);

    // Randomized searches
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 5);
      ks.delete();
      for (int i = 0; i < n; i++) ks.push_back($urandom);
      rc = {$urandom, $urandom};
      h  = $urandom_range(0, n);
      rt = (h < n) ? decrypt(rc, ks[h]) : {$urandom, $urandom};
      st = $urandom_range(0, 6);
      if (h == n) sp = $urandom_range(1, n * (R + 2) + st + 3);
      else        sp = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : -1;
      rs = $urandom_range(2, 5);
      run($sformatf("rand%0d", r), rc, rt, ks, st, sp, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
